// File: rtl/parity_rotator.sv
// Parity-feedback rotating register: each step overwrites the bit at a rotating
// index with the (optionally inverted) parity of the whole register.
module parity_rotator #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] INIT        = {WIDTH{1'b1}},
  parameter int               COUNT_WIDTH = 16,
  localparam int              IW          = $clog2(WIDTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_value,
  input  logic                   invert,
  output logic [WIDTH-1:0]       state,
  output logic [IW-1:0]          index,
  output logic                   parity,
  output logic                   wrap,
  output logic                   match,
  output logic [COUNT_WIDTH-1:0] period,
  output logic                   period_valid
);

  logic [WIDTH-1:0]       start_state;
  logic [COUNT_WIDTH-1:0] steps;

  logic [WIDTH-1:0]       state_step;
  logic [IW-1:0]          index_step;
  logic [COUNT_WIDTH-1:0] steps_step;
  logic                   last_index;
  logic                   is_return;

  assign parity = ^state ^ invert;

  // Candidate next values for an enabled step; index wraps explicitly so that
  // non-power-of-two widths never address a missing bit.
  always_comb begin
    state_step        = state;
    state_step[index] = parity;
    last_index        = (index == IW'(WIDTH - 1));
    index_step        = last_index ? '0 : index + IW'(1);
    steps_step        = (&steps) ? steps : steps + COUNT_WIDTH'(1);
    is_return         = (state_step == start_state) && (index_step == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= INIT;
      start_state  <= INIT;
      index        <= '0;
      steps        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      wrap         <= 1'b0;
      match        <= 1'b0;
    end else if (load) begin
      state        <= load_value;
      start_state  <= load_value;
      index        <= '0;
      steps        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      wrap         <= 1'b0;
      match        <= 1'b0;
    end else if (enable) begin
      state <= state_step;
      index <= index_step;
      steps <= steps_step;
      wrap  <= last_index;
      match <= is_return;
      // Only the first return after reset/load latches the period.
      if (is_return && !period_valid) begin
        period       <= steps_step;
        period_valid <= 1'b1;
      end
    end else begin
      wrap  <= 1'b0;
      match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_parity_rotator.sv
// Self-checking bench: a table of reference steps plus a scoreboard fed by a
// behavioural model, driving a 16-bit-counter and a 4-bit-counter instance.
module tb_parity_rotator;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  load_value = 4'b0000;
  logic        invert = 1'b0;

  logic [3:0]  state;
  logic [1:0]  index;
  logic        parity, wrap, match, period_valid;
  logic [15:0] period;

  logic [3:0]  s_state;
  logic [1:0]  s_index;
  logic        s_parity, s_wrap, s_match, s_period_valid;
  logic [3:0]  s_period;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  parity_rotator #(.WIDTH(4), .COUNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .load_value(load_value), .invert(invert), .state(state), .index(index),
    .parity(parity), .wrap(wrap), .match(match), .period(period),
    .period_valid(period_valid)
  );

  parity_rotator #(.WIDTH(4), .COUNT_WIDTH(4)) dut_s (
    .clock(clock), .reset(reset), .enable(enable), .load(load),
    .load_value(load_value), .invert(invert), .state(s_state), .index(s_index),
    .parity(s_parity), .wrap(s_wrap), .match(s_match), .period(s_period),
    .period_valid(s_period_valid)
  );

  typedef struct {
    logic [3:0]  st;
    logic [1:0]  idx;
    logic        par;
    logic        wrap;
    logic        match;
    logic [15:0] per;
    logic        pv;
    logic [3:0]  per_s;
    logic        pv_s;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [3:0] lv;
    logic       en;
    logic       inv;
    logic [3:0] exp_state;
    logic [1:0] exp_index;
    logic       exp_wrap;
  } vec_t;

  exp_t sb[$];

  // Reference model: plain integer step count, parity by counting ones.
  logic [3:0]  m_state, m_start;
  int          m_idx, m_steps;
  logic        m_pv, m_pv_s;
  logic [15:0] m_per;
  logic [3:0]  m_per_s;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ld, input logic [3:0] lv,
                               input logic en, input logic inv);
    exp_t e;
    int   fb;
    @(negedge clock);
    reset = rst; load = ld; load_value = lv; enable = en; invert = inv;
    e.wrap = 1'b0;
    e.match = 1'b0;
    if (rst || ld) begin
      m_state = rst ? 4'b1111 : lv;
      m_start = m_state;
      m_idx = 0; m_steps = 0;
      m_per = '0; m_pv = 1'b0; m_per_s = '0; m_pv_s = 1'b0;
    end else if (en) begin
      fb = ($countones(m_state) + int'(inv)) % 2;
      m_state[m_idx] = fb[0];
      e.wrap = (m_idx == 3);
      m_idx = (m_idx + 1) % 4;
      m_steps++;
      if (m_state == m_start && m_idx == 0) begin
        e.match = 1'b1;
        if (!m_pv) begin
          m_pv = 1'b1;
          m_per = (m_steps > 65535) ? 16'hFFFF : 16'(m_steps);
        end
        if (!m_pv_s) begin
          m_pv_s = 1'b1;
          m_per_s = (m_steps > 15) ? 4'hF : 4'(m_steps);
        end
      end
    end
    e.st = m_state;
    e.idx = 2'(m_idx);
    e.par = 1'(($countones(m_state) + int'(inv)) % 2);
    e.per = m_per; e.pv = m_pv; e.per_s = m_per_s; e.pv_s = m_pv_s;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checkVal("scoreboard_empty", 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    checkVal("state", 32'(state), 32'(e.st));
    checkVal("index", 32'(index), 32'(e.idx));
    checkVal("parity", 32'(parity), 32'(e.par));
    checkVal("wrap", 32'(wrap), 32'(e.wrap));
    checkVal("match", 32'(match), 32'(e.match));
    checkVal("period", 32'(period), 32'(e.per));
    checkVal("period_valid", 32'(period_valid), 32'(e.pv));
    checkVal("sat_state", 32'(s_state), 32'(e.st));
    checkVal("sat_period", 32'(s_period), 32'(e.per_s));
    checkVal("sat_period_valid", 32'(s_period_valid), 32'(e.pv_s));
  endtask

  task automatic runSteps(input int n, input logic inv);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1, inv);
      checkOutput();
    end
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1111, 2'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1110, 2'd1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1110, 2'd2, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1110, 2'd3, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1110, 2'd0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1111, 2'd1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1101, 2'd2, 1'b0};

    // Reset plus the first six reference steps.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].inv);
      checkOutput();
      checkVal($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
      checkVal($sformatf("vec%0d_index", i), 32'(index), 32'(vecs[i].exp_index));
      checkVal($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
    end
    checkVal("reset_period", 32'(period), 32'd0);

    // Finish the first period at step 20.
    runSteps(14, 1'b0);
    checkVal("p20_state", 32'(state), 32'hF);
    checkVal("p20_index", 32'(index), 32'd0);
    checkVal("p20_match", 32'(match), 32'd1);
    checkVal("p20_period", 32'(period), 32'd20);
    checkVal("p20_valid", 32'(period_valid), 32'd1);
    checkVal("p20_sat_period", 32'(s_period), 32'd15);
    checkVal("p20_sat_valid", 32'(s_period_valid), 32'd1);

    // A few steps, a five-cycle hold, then on to step 40.
    runSteps(3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
      checkOutput();
      checkVal("hold_wrap", 32'(wrap), 32'd0);
      checkVal("hold_match", 32'(match), 32'd0);
    end
    runSteps(17, 1'b0);
    checkVal("p40_match", 32'(match), 32'd1);
    checkVal("p40_period", 32'(period), 32'd20);
    runSteps(1, 1'b0);
    checkVal("p41_match", 32'(match), 32'd0);

    // Reset at step 10, then a fresh period.
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    checkOutput();
    runSteps(10, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
    checkOutput();
    checkVal("rst10_state", 32'(state), 32'hF);
    checkVal("rst10_index", 32'(index), 32'd0);
    checkVal("rst10_period", 32'(period), 32'd0);
    checkVal("rst10_valid", 32'(period_valid), 32'd0);
    runSteps(20, 1'b0);
    checkVal("rst10_new_period", 32'(period), 32'd20);
    checkVal("rst10_new_valid", 32'(period_valid), 32'd1);

    // Load wins over enable; then inverted-parity steps from 0000.
    runSteps(2, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b1, 1'b1);
    checkOutput();
    checkVal("ld_state", 32'(state), 32'h0);
    checkVal("ld_index", 32'(index), 32'd0);
    runSteps(1, 1'b1);
    checkVal("inv1_state", 32'(state), 32'h1);
    checkVal("inv1_parity", 32'(parity), 32'd0);
    checkVal("inv1_valid", 32'(period_valid), 32'd0);
    runSteps(1, 1'b1);
    checkVal("inv2_state", 32'(state), 32'h1);
    checkVal("inv2_valid", 32'(period_valid), 32'd0);

    checkVal("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parity_rotator.md
# parity_rotator

Parametrised parity-feedback rotating register: each enabled cycle, the bit at a rotating index is overwritten with the (optionally inverted) parity of the whole register. It generalises the fixed 4-bit parity rotator to any width and adds a load port, odd/even feedback mode, a wrap pulse, and hardware period detection. It sits beside test-pattern and scrambler logic as a small self-checking sequence source.

## Interface
- WIDTH, 4, register width; legal range ≥ 2.
- INIT, all ones (WIDTH bits), state value after reset.
- COUNT_WIDTH, 16, width of the step counter and the period output; legal range ≥ 2.
- IW (local), $clog2(WIDTH), index width.

Ports:
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; overrides everything.
- enable  in  1  advance one step this cycle.
- load  in  1  load load_value; has priority over enable.
- load_value  in  WIDTH  value taken on load.
- invert  in  1  0: feedback = even parity; 1: feedback = inverted parity. Sampled every cycle.
- state  out  WIDTH  current register.
- index  out  IW  bit position updated on the next step.
- parity  out  1  combinational: ^state ^ invert, i.e. the next feedback bit.
- wrap  out  1  one-cycle pulse, registered.
- match  out  1  one-cycle pulse, registered.
- period  out  COUNT_WIDTH  latched period length.
- period_valid  out  1  period holds a valid value.

## Operation
- Internal registers: start_state (WIDTH) and steps (COUNT_WIDTH, saturating at all ones).
- Priority per cycle: reset > load > enable > hold.
- reset: state=INIT, start_state=INIT, index=0, steps=0, period=0, period_valid=0, wrap=0, match=0.
- load: state=load_value, start_state=load_value, index=0, steps=0, period=0, period_valid=0, wrap=0, match=0.
- Step (enable=1, no load/reset):
  - fb = parity as seen this cycle.
  - state_next = state with bit[index] replaced by fb; other bits unchanged.
  - index_next = (index == WIDTH-1) ? 0 : index+1. This holds for non-power-of-two WIDTH; index never exceeds WIDTH-1.
  - wrap=1 when index == WIDTH-1, else 0.
  - steps_next = steps+1, saturating at 2^COUNT_WIDTH-1.
  - Return condition: state_next == start_state and index_next == 0.
  - On a return, match=1.
  - On the first return since reset/load, also period = steps_next (already saturated if needed) and period_valid=1.
  - Later returns pulse match but leave period unchanged.
- Hold (enable=0): all registers keep their values; wrap=0, match=0.
- period and period_valid change only on reset, load, or the first return.

## Timing
- Step latency 1 cycle: values presented with enable at edge N appear on state/index at edge N.
- wrap and match are asserted in the same cycle the updated state becomes visible, for exactly one cycle.
- parity is combinational from state and invert, with zero latency.
- load or reset in the middle of a period discards the partial count; the next period measures from the new start_state.
- load and enable both high: load wins and no step occurs.
- Step counter saturation: steps sticks at all ones, and a later first return reports period = all ones.

## Test plan
- WIDTH=4, reset, invert=0, enable=1:
  - Required states after steps 1..6: 1110, 1110, 1110, 1110, 1111, 1101.
  - wrap pulses after step 4 only.
  - index after step 6 = 2.
- Same setup, 20 steps:
  - After step 20: state=1111, index=0, match=1 for one cycle, period=20, period_valid=1.
  - After step 40: match pulses again and period stays 20.
- COUNT_WIDTH=4, same stimulus:
  - steps saturates at 15.
  - At step 20: period=15, period_valid=1.
- load_value=0000 with invert=1, then 2 steps:
  - After step 1: state=0001, parity=0.
  - After step 2: state=0001.
  - period_valid=0 throughout.
- Holds and priority:
  - enable low for 5 cycles mid-sequence: state, index, and steps unchanged; wrap=0, match=0.
  - load and enable together: the loaded value is taken and index=0.
- Reset asserted at step 10: the next cycle shows state=1111, index=0, period=0, period_valid=0, and a fresh period of 20 is measured afterwards.
